// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential signed multiplier: state encoding,
// default operand width and the iteration-counter width rule.
package mul_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_MUL  = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int DEFAULT_L = 16;

    // Counter must reach L, one past the last MUL iteration index.
    function automatic int cnt_w(input int l);
        return $clog2(l + 1);
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// Operand, accumulator and result registers for the shift-add multiplier.
// Negator/adder/shift are enabled one step per cycle by mul_seq_ctrl.
module mul_datapath
    import mul_seq_ctrl_pkg::*;
#(
    parameter int L = DEFAULT_L
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           abs_i,
    input  logic           step_i,
    input  logic           sign_i,
    input  logic [L-1:0]   a_i,
    input  logic [L-1:0]   b_i,
    output logic [2*L-1:0] product_o,
    output logic           ovf_lo_o
);

    logic [L-1:0]   a_q, a_d, b_q, b_d;
    logic [L-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic           sign_q, sign_d;
    logic [2*L:0]   acc_q, acc_d;
    logic [2*L-1:0] product_q, product_d;
    logic           ovf_q, ovf_d;

    logic [L:0]     sum;
    logic [2*L:0]   acc_add;
    logic [2*L-1:0] mag, signed_prod;
    logic [L:0]     hi_bits;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        // Adder works on the upper half; acc_q[2L] is the carry slot.
        sum         = acc_q[2*L:L] + {1'b0, (mplier_q[0] ? mcand_q : {L{1'b0}})};
        acc_add     = {sum, acc_q[L-1:0]};
        mag         = acc_q[2*L-1:0];
        signed_prod = sign_q ? (~mag + (2*L)'(1)) : mag;
        hi_bits     = signed_prod[2*L-1:L-1];

        if (load_i) begin
            a_d    = a_i;
            b_d    = b_i;
            sign_d = a_i[L-1] ^ b_i[L-1];
        end
        if (abs_i) begin
            // -2^(L-1) negates to itself, which read unsigned is the right magnitude.
            mcand_d  = a_q[L-1] ? (~a_q + L'(1)) : a_q;
            mplier_d = b_q[L-1] ? (~b_q + L'(1)) : b_q;
            acc_d    = '0;
        end
        if (step_i) begin
            acc_d    = acc_add >> 1;
            mplier_d = mplier_q >> 1;
        end
        if (sign_i) begin
            product_d = signed_prod;
            ovf_d     = !((&hi_bits) || !(|hi_bits));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign product_o = product_q;
    assign ovf_lo_o  = ovf_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential signed multiplier: IDLE, ABS, L x MUL, SIGN, DONE; one op per L+4 cycles.
// in_ready only in IDLE; result held in DONE until out_ready.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int L = DEFAULT_L
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [L-1:0]   a,
    input  logic [L-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*L-1:0] product,
    output logic           ovf_lo
);

    localparam int CW = cnt_w(L);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_en, abs_en, step_en, sign_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_en   = 1'b0;
        abs_en    = 1'b0;
        step_en   = 1'b0;
        sign_en   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                abs_en  = 1'b1;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                step_en = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(L - 1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                sign_en = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mul_datapath #(.L(L)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_en),
        .abs_i     (abs_en),
        .step_i    (step_en),
        .sign_i    (sign_en),
        .a_i       (a),
        .b_i       (b),
        .product_o (product),
        .ovf_lo_o  (ovf_lo)
    );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl at L=4 and L=16 sharing one clock.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // L = 4 instance
    logic       rst4_n, iv4, ir4, ov4, or4, ovf4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    mul_seq_ctrl #(.L(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .product(p4), .ovf_lo(ovf4)
    );

    // L = 16 instance
    logic        rst16_n, iv16, ir16, ov16, or16, ovf16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    mul_seq_ctrl #(.L(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .product(p16), .ovf_lo(ovf16)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the L=4 instance (out_ready high) and check its result.
    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] ep, input logic eo);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, ir4, 1'b1);
        a4 = a; b4 = b; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'(~a); b4 = 4'(~b);
        n = 0;
        while (!ov4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, ov4, 1'b1);
        chk({tag, "_product"}, p4, ep);
        chk({tag, "_ovf_lo"}, ovf4, eo);
        @(negedge clk);
        chk({tag, "_ready_again"}, ir4, 1'b1);
        chk({tag, "_valid_dropped"}, ov4, 1'b0);
        chk({tag, "_product_held"}, p4, ep);
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a16 = a; b16 = b; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    task automatic wait16(input string tag);
        int n;
        n = 0;
        while (!ov16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, ov16, 1'b1);
    endtask

    logic [15:0] ta [3] = '{16'd5, 16'hFFF9, 16'd32767};
    logic [15:0] tb [3] = '{16'd6, 16'd7, 16'd2};
    logic [31:0] tp [3] = '{32'd30, 32'hFFFF_FFCF, 32'd65534};
    logic        to [3] = '{1'b0, 1'b0, 1'b1};
    int          acc_cyc [3];

    initial begin
        int k_acc, k_res;
        rst4_n = 1'b0; rst16_n = 1'b0;
        iv4 = 1'b0; iv16 = 1'b0; or4 = 1'b1; or16 = 1'b1;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0;
        #3;
        chk("rst4_in_ready", ir4, 1'b1);
        chk("rst4_out_valid", ov4, 1'b0);
        chk("rst4_product", p4, 8'h00);
        chk("rst4_ovf", ovf4, 1'b0);
        chk("rst16_in_ready", ir16, 1'b1);
        chk("rst16_out_valid", ov16, 1'b0);
        chk("rst16_product", p16, 32'h0);
        @(negedge clk);
        rst4_n = 1'b1; rst16_n = 1'b1;

        // L=4 directed products
        op4("t1_3x-2", 4'd3, 4'hE, 8'hFA, 1'b0);
        op4("t2_-8x-8", 4'h8, 4'h8, 8'h40, 1'b1);
        op4("t3_-8x7", 4'h8, 4'd7, 8'hC8, 1'b1);
        op4("t3_0x-5", 4'd0, 4'hB, 8'h00, 1'b0);

        // L=16 held result under backpressure
        or16 = 1'b0;
        start16(16'hFFFF, 16'hFFFF);
        wait16("t4");
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", ov16, 1'b1);
            chk("t4_hold_product", p16, 32'd1);
            chk("t4_hold_ovf", ovf16, 1'b0);
            chk("t4_hold_in_ready", ir16, 1'b0);
            @(negedge clk);
        end
        or16 = 1'b1;
        chk("t4_ready_before_edge", ir16, 1'b0);
        @(negedge clk);
        chk("t4_in_ready_after", ir16, 1'b1);
        chk("t4_valid_after", ov16, 1'b0);
        chk("t4_product_kept", p16, 32'd1);

        // Reset in the middle of MUL discards the operation
        start16(16'd1234, 16'hFFB3);
        repeat (5) @(negedge clk);
        rst16_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", ov16, 1'b0);
        chk("t5_rst_product", p16, 32'h0);
        chk("t5_rst_ovf", ovf16, 1'b0);
        chk("t5_rst_in_ready", ir16, 1'b1);
        @(negedge clk);
        rst16_n = 1'b1;
        start16(16'd300, 16'd300);
        wait16("t5");
        chk("t5_product", p16, 32'd90000);
        chk("t5_ovf", ovf16, 1'b1);
        @(negedge clk);
        chk("t5_in_ready", ir16, 1'b1);

        // in_valid held high with changing operands; only IDLE-edge operands count
        k_acc = 0; k_res = 0;
        for (int c = 0; c < 200 && k_res < 3; c++) begin
            @(negedge clk);
            if (ov16) begin
                chk("t6_product", p16, tp[k_res]);
                chk("t6_ovf", ovf16, to[k_res]);
                k_res++;
            end
            if (ir16 && k_acc < 3) begin
                a16 = ta[k_acc]; b16 = tb[k_acc]; iv16 = 1'b1;
                acc_cyc[k_acc] = cyc;
                k_acc++;
            end else if (k_acc < 3 || !ir16) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                iv16 = (k_acc < 3);
            end else begin
                iv16 = 1'b0;
            end
        end
        iv16 = 1'b0;
        chk("t6_result_count", 64'(k_res), 64'd3);
        chk("t6_throughput_0_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd20);
        chk("t6_throughput_1_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
